// File: rtl/xpb_lut_bank.sv
// Bank of NUM_TABLES lookup tables of reduced-residue multiples, loaded over a write port
// and read through one fully pipelined lane per table with a fixed 2-cycle latency.
module xpb_lut_bank #(
  parameter int DATA_W     = 1024,
  parameter int ADDR_W     = 5,
  parameter int NUM_TABLES = 4,
  localparam int TBL_W     = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [TBL_W-1:0]               wr_table,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
  output logic                           wr_err,
  input  logic                           lk_valid,
  input  logic [NUM_TABLES*ADDR_W-1:0]   lk_idx,
  output logic                           out_valid,
  output logic [NUM_TABLES*DATA_W-1:0]   out_data,
  output logic                           out_err,
  output logic                           tables_ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_LOADING,
    ST_READY
  } state_t;

  state_t                          state_q, state_d;
  logic                            run_q, run_d;
  logic [NUM_TABLES*DEPTH-1:0]     valid_q, valid_d;
  logic                            wr_err_q, wr_err_d;
  logic                            s1_valid_q, s1_valid_d;
  logic                            s1_err_q, s1_err_d;
  logic [NUM_TABLES*ADDR_W-1:0]    s1_idx_q, s1_idx_d;
  logic                            out_valid_q, out_valid_d;
  logic                            out_err_q, out_err_d;
  logic [NUM_TABLES*DATA_W-1:0]    out_data_q, out_data_d;

  logic                            wr_fire;
  logic                            wr_bad;
  logic                            wr_store;
  logic [NUM_TABLES-1:0]           tbl_full;
  logic                            all_valid;
  logic [NUM_TABLES*DATA_W-1:0]    rd_data;
  logic [NUM_TABLES*DATA_W-1:0]    lane_data;

  assign wr_ready = run_q & ~clear;
  assign wr_fire  = wr_valid & wr_ready;
  assign wr_bad   = (wr_addr == '0) || ({1'b0, wr_table} >= (TBL_W + 1)'(NUM_TABLES));
  assign wr_store = wr_fire & ~wr_bad;

  // Entry 0 never gets a valid bit of its own; it reads as zero and is excluded from the full check.
  for (genvar gi = 0; gi < NUM_TABLES; gi++) begin : g_tbl
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;

    assign tbl_full[gi] = &valid_q[gi*DEPTH+1 +: DEPTH-1];

    // Read-first RAM: a same-edge write is not visible to the read issued on that edge.
    always_ff @(posedge clk) begin
      if (wr_store && (wr_table == TBL_W'(gi))) begin
        mem[wr_addr] <= wr_data;
      end
      if (lk_valid) begin
        rd_q <= mem[lk_idx[gi*ADDR_W +: ADDR_W]];
      end
    end

    assign rd_data[gi*DATA_W +: DATA_W]   = rd_q;
    assign lane_data[gi*DATA_W +: DATA_W] =
      (s1_idx_q[gi*ADDR_W +: ADDR_W] == '0) ? '0 : rd_q;
  end

  assign all_valid = &tbl_full;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY:   if (wr_store)  state_d = ST_LOADING;
        ST_LOADING: if (all_valid) state_d = ST_READY;
        ST_READY:   state_d = ST_READY;
        default:    state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    run_d    = 1'b1;
    valid_d  = valid_q;
    wr_err_d = wr_fire & wr_bad;
    if (clear) begin
      valid_d = '0;
    end else if (wr_store) begin
      valid_d[{wr_table, wr_addr}] = 1'b1;
    end
  end

  // Error status is fixed at issue time so lookups already in flight survive a clear.
  always_comb begin
    s1_valid_d  = lk_valid;
    s1_err_d    = (state_q != ST_READY) | clear;
    s1_idx_d    = lk_valid ? lk_idx : s1_idx_q;
    out_valid_d = s1_valid_q;
    out_err_d   = s1_valid_q & s1_err_q;
    out_data_d  = out_data_q;
    if (s1_valid_q) begin
      out_data_d = s1_err_q ? '0 : lane_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      run_q       <= 1'b0;
      valid_q     <= '0;
      wr_err_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      valid_q     <= valid_d;
      wr_err_q    <= wr_err_d;
      s1_valid_q  <= s1_valid_d;
      s1_err_q    <= s1_err_d;
      s1_idx_q    <= s1_idx_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      out_data_q  <= out_data_d;
    end
  end

  assign wr_err       = wr_err_q;
  assign out_valid    = out_valid_q;
  assign out_err      = out_err_q;
  assign out_data     = out_data_q;
  assign tables_ready = (state_q == ST_READY);

endmodule
